// File: rtl/nodf_mon_pkg.sv
// Shared types and defaults for the ap_ctrl handshake status tracker.
package nodf_mon_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;
    localparam int unsigned DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        DONE_WAIT = 2'd2,
        FINISHED  = 2'd3
    } status_e;

endpackage

// File: rtl/nodf_module_intf_if.sv
// Handshake inputs and statistics outputs of the status tracker, bundled as one interface.
interface nodf_module_intf_if
    import nodf_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             finish;

    status_e          status;
    logic [CNT_W-1:0] start_cnt;
    logic [CNT_W-1:0] done_cnt;
    logic [CW-1:0]    outstanding;
    logic [CNT_W-1:0] last_latency;
    logic [CNT_W-1:0] last_interval;
    logic [CNT_W-1:0] stall_cycles;
    logic             sample_valid;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue, finish,
        input  status, start_cnt, done_cnt, outstanding, last_latency,
               last_interval, stall_cycles, sample_valid, ovf_err, unf_err
    );

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue, finish,
        output status, start_cnt, done_cnt, outstanding, last_latency,
               last_interval, stall_cycles, sample_valid, ovf_err, unf_err
    );

endinterface

// File: rtl/ts_fifo.sv
// Timestamp FIFO for outstanding transactions; supports push and pop in the same cycle.
module ts_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           data_i,
    output logic [W-1:0]           head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          doPush, doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign doPush = push_i & (~full_o | pop_i);
    assign doPop  = pop_i & ~empty_o;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/nodf_module_intf.sv
// Status tracker for one non-dataflow HLS kernel: counts starts/completions,
// measures latency and start interval, and reports run state until finish.
module nodf_module_intf
    import nodf_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    nodf_module_intf_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    status_e          state_q, state_d;
    logic [CNT_W-1:0] ts_q;
    logic [CNT_W-1:0] startCnt_q, startCnt_d;
    logic [CNT_W-1:0] doneCnt_q, doneCnt_d;
    logic [CNT_W-1:0] latency_q, latency_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] prevAcceptTs_q, prevAcceptTs_d;
    logic             havePrev_q, havePrev_d;
    logic             sampleValid_q, sampleValid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             frozen, accept, complete, comboTxn;
    logic             fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [CNT_W-1:0] fifoHead;
    logic [CW-1:0]    fifoCount, newCount;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign frozen   = bus.finish | (state_q == FINISHED);
    assign accept   = bus.ap_start & bus.ap_ready & ~frozen;
    assign complete = bus.ap_done & bus.ap_continue & ~frozen;

    // Accept and complete together on an empty FIFO is a zero-latency kernel: nothing is stored.
    assign comboTxn = accept & complete & fifoEmpty;
    assign fifoPush = accept & ~comboTxn & (~fifoFull | complete);
    assign fifoPop  = complete & ~fifoEmpty;
    assign newCount = fifoCount + CW'(fifoPush) - CW'(fifoPop);

    ts_fifo #(
        .W     (CNT_W),
        .DEPTH (DEPTH)
    ) u_tsFifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .data_i  (ts_q),
        .head_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    always_comb begin
        state_d = state_q;
        if (bus.finish || state_q == FINISHED) begin
            state_d = FINISHED;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && !(complete && newCount == '0)) begin
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (bus.ap_done && !bus.ap_continue) begin
                        state_d = DONE_WAIT;
                    end else if (complete && newCount == '0) begin
                        state_d = IDLE;
                    end
                end
                DONE_WAIT: begin
                    if (complete) begin
                        state_d = (newCount != '0) ? BUSY : IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        startCnt_d     = startCnt_q;
        doneCnt_d      = doneCnt_q;
        latency_d      = latency_q;
        interval_d     = interval_q;
        stall_d        = stall_q;
        prevAcceptTs_d = prevAcceptTs_q;
        havePrev_d     = havePrev_q;
        sampleValid_d  = complete;
        ovf_d          = ovf_q;
        unf_d          = unf_q;

        if (accept) begin
            startCnt_d     = satInc(startCnt_q);
            interval_d     = havePrev_q ? (ts_q - prevAcceptTs_q) : '0;
            prevAcceptTs_d = ts_q;
            havePrev_d     = 1'b1;
            if (fifoFull && !complete) begin
                ovf_d = 1'b1;
            end
        end

        if (complete) begin
            doneCnt_d = satInc(doneCnt_q);
            latency_d = fifoEmpty ? '0 : (ts_q - fifoHead);
            if (fifoEmpty && !accept) begin
                unf_d = 1'b1;
            end
        end

        if (!frozen && bus.ap_done && !bus.ap_continue) begin
            stall_d = satInc(stall_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            ts_q           <= '0;
            startCnt_q     <= '0;
            doneCnt_q      <= '0;
            latency_q      <= '0;
            interval_q     <= '0;
            stall_q        <= '0;
            prevAcceptTs_q <= '0;
            havePrev_q     <= 1'b0;
            sampleValid_q  <= 1'b0;
            ovf_q          <= 1'b0;
            unf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            ts_q           <= ts_q + CNT_W'(1);
            startCnt_q     <= startCnt_d;
            doneCnt_q      <= doneCnt_d;
            latency_q      <= latency_d;
            interval_q     <= interval_d;
            stall_q        <= stall_d;
            prevAcceptTs_q <= prevAcceptTs_d;
            havePrev_q     <= havePrev_d;
            sampleValid_q  <= sampleValid_d;
            ovf_q          <= ovf_d;
            unf_q          <= unf_d;
        end
    end

    assign bus.status        = state_q;
    assign bus.start_cnt     = startCnt_q;
    assign bus.done_cnt      = doneCnt_q;
    assign bus.outstanding   = fifoCount;
    assign bus.last_latency  = latency_q;
    assign bus.last_interval = interval_q;
    assign bus.stall_cycles  = stall_q;
    assign bus.sample_valid  = sampleValid_q;
    assign bus.ovf_err       = ovf_q;
    assign bus.unf_err       = unf_q;

endmodule

// File: tb/tb_nodf_module_intf.sv
// Directed-vector bench for the ap_ctrl status tracker with hand-computed expectations.
module tb_nodf_module_intf;
    import nodf_mon_pkg::*;

    localparam int CNT_W = 32;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   peakOut;

    nodf_module_intf_if #(.CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

    nodf_module_intf #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic applyStimulus(input logic start, input logic ready, input logic done,
                                 input logic cont, input logic fin);
        bus.ap_start    = start;
        bus.ap_ready    = ready;
        bus.ap_done     = done;
        bus.ap_continue = cont;
        bus.finish      = fin;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] reset idle");
        doReset();
        for (int i = 0; i < 10; i++) begin
            checkOutput("idleStatus", 32'(bus.status), 32'(IDLE));
            checkOutput("idleAllZero", 32'(|{bus.start_cnt, bus.done_cnt, bus.last_latency,
                        bus.last_interval, bus.stall_cycles, bus.outstanding,
                        bus.sample_valid, bus.ovf_err, bus.unf_err}), 0);
            step(1);
        end

        $display("[TB] single transaction latency 7");
        doReset();
        step(3);
        applyStimulus(1, 1, 0, 1, 0);
        step(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("singleBusy", 32'(bus.status), 32'(BUSY));
        checkOutput("singleOut", 32'(bus.outstanding), 1);
        checkOutput("firstInterval", bus.last_interval, 0);
        step(6);
        checkOutput("singleNoSample", 32'(bus.sample_valid), 0);
        applyStimulus(0, 0, 1, 1, 0);
        step(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("singleLatency", bus.last_latency, 7);
        checkOutput("singleSample", 32'(bus.sample_valid), 1);
        checkOutput("singleStarts", bus.start_cnt, 1);
        checkOutput("singleDones", bus.done_cnt, 1);
        checkOutput("singleIdle", 32'(bus.status), 32'(IDLE));
        step(1);
        checkOutput("singlePulseEnd", 32'(bus.sample_valid), 0);

        $display("[TB] three pipelined transactions");
        doReset();
        peakOut = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus((c == 0 || c == 4 || c == 8), 1,
                          (c == 10 || c == 14 || c == 18), 1, 0);
            step(1);
            if (int'(bus.outstanding) > peakOut) peakOut = int'(bus.outstanding);
            if (c == 4) checkOutput("pipeInterval1", bus.last_interval, 4);
            if (c == 8) begin
                checkOutput("pipeInterval2", bus.last_interval, 4);
                checkOutput("pipeOut3", 32'(bus.outstanding), 3);
            end
            if (c == 10 || c == 14 || c == 18) begin
                checkOutput("pipeLatency", bus.last_latency, 10);
                checkOutput("pipeSample", 32'(bus.sample_valid), 1);
            end
            if (c == 11) checkOutput("pipeOutAfterDone", 32'(bus.outstanding), 2);
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("pipePeak", 32'(peakOut), 3);
        checkOutput("pipeStarts", bus.start_cnt, 3);
        checkOutput("pipeDones", bus.done_cnt, 3);
        checkOutput("pipeIdle", 32'(bus.status), 32'(IDLE));

        $display("[TB] done stall with backpressure");
        doReset();
        applyStimulus(1, 1, 0, 1, 0);
        step(1);
        applyStimulus(0, 0, 0, 1, 0);
        step(2);
        applyStimulus(0, 0, 1, 0, 0);
        step(1);
        checkOutput("stallState", 32'(bus.status), 32'(DONE_WAIT));
        checkOutput("stallCount1", bus.stall_cycles, 1);
        step(4);
        checkOutput("stallState5", 32'(bus.status), 32'(DONE_WAIT));
        checkOutput("stallCount5", bus.stall_cycles, 5);
        checkOutput("stallNoDone", bus.done_cnt, 0);
        applyStimulus(0, 0, 1, 1, 0);
        step(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("stallDone", bus.done_cnt, 1);
        checkOutput("stallLatency", bus.last_latency, 8);
        checkOutput("stallIdle", 32'(bus.status), 32'(IDLE));
        step(1);
        checkOutput("stallDoneOnce", bus.done_cnt, 1);
        checkOutput("stallHeld", bus.stall_cycles, 5);

        $display("[TB] combinational transaction and underflow");
        applyStimulus(1, 1, 1, 1, 0);
        step(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("comboLatency", bus.last_latency, 0);
        checkOutput("comboSample", 32'(bus.sample_valid), 1);
        checkOutput("comboOut", 32'(bus.outstanding), 0);
        checkOutput("comboStarts", bus.start_cnt, 2);
        checkOutput("comboDones", bus.done_cnt, 2);
        checkOutput("comboNoUnf", 32'(bus.unf_err), 0);
        checkOutput("comboNoOvf", 32'(bus.ovf_err), 0);
        applyStimulus(0, 0, 1, 1, 0);
        step(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("unfErr", 32'(bus.unf_err), 1);
        checkOutput("unfDones", bus.done_cnt, 3);
        checkOutput("unfSample", 32'(bus.sample_valid), 1);
        step(2);
        checkOutput("unfSticky", 32'(bus.unf_err), 1);

        $display("[TB] overflow then finish");
        doReset();
        applyStimulus(1, 1, 0, 1, 0);
        step(4);
        checkOutput("fullOut", 32'(bus.outstanding), DEPTH);
        checkOutput("fullNoOvf", 32'(bus.ovf_err), 0);
        step(1);
        checkOutput("ovfErr", 32'(bus.ovf_err), 1);
        checkOutput("ovfStarts", bus.start_cnt, DEPTH + 1);
        checkOutput("ovfOut", 32'(bus.outstanding), DEPTH);
        applyStimulus(1, 1, 1, 1, 1);
        step(1);
        checkOutput("finState", 32'(bus.status), 32'(FINISHED));
        checkOutput("finStarts", bus.start_cnt, DEPTH + 1);
        checkOutput("finDones", bus.done_cnt, 0);
        checkOutput("finNoSample", 32'(bus.sample_valid), 0);
        applyStimulus(1, 1, 1, 0, 0);
        step(3);
        checkOutput("frozenState", 32'(bus.status), 32'(FINISHED));
        checkOutput("frozenStarts", bus.start_cnt, DEPTH + 1);
        checkOutput("frozenStall", bus.stall_cycles, 0);
        checkOutput("frozenOut", 32'(bus.outstanding), DEPTH);

        $display("[TB] reset mid-run then stray done");
        doReset();
        checkOutput("rstState", 32'(bus.status), 32'(IDLE));
        checkOutput("rstOut", 32'(bus.outstanding), 0);
        checkOutput("rstOvf", 32'(bus.ovf_err), 0);
        applyStimulus(0, 0, 1, 1, 0);
        step(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("rstUnf", 32'(bus.unf_err), 1);
        checkOutput("rstDones", bus.done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
